track_transport: RTL

//  Single-clock transport sequencer between the synchronised I2S sample strobe and track_store_load.

---
 rtl/track_transport.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/track_transport.sv
// track_transport
//   Transport sequencer between the synchronised I2S sample strobe and the
//   track store. It owns the IDLE/PLAY/RECORD/DRAIN state, the shared sample
//   position (with optional loop wrap) and the per-frame write beats.
//
// Ports
//   clk_in, rst_in          single clock, synchronous active-high reset
//   sample_strobe           one-cycle pulse per sample frame
//   play_req/record_req/stop_req  one-cycle transport requests (stop > record > play)
//   arm                     record-arm mask, captured on each strobe in RECORD
//   loop_en/loop_start/loop_end   inclusive loop window
//   adc_in                  sample captured on the strobe
//   wr_valid/wr_ready/wr_data/wr_channel   write beat handshake toward the store
//   rd_req                  one-cycle mixed-read request per PLAY frame
//   position                current frame position
//   state_out               0 IDLE, 1 PLAY, 2 RECORD, 3 DRAIN
//   overrun                 sticky: a strobe arrived with beats still pending
//
// state   | meaning
// IDLE    | stopped, strobes ignored
// PLAY    | one rd_req and one position step per strobe
// RECORD  | one write beat per armed channel per strobe, ascending order
// DRAIN   | finishing the in-flight beat, then IDLE (or PLAY)

module track_transport #(
  parameter int WORD_WIDTH = 8,
  parameter int CHANNELS   = 8,
  parameter int POS_WIDTH  = 24,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  sample_strobe,
  input  logic                  play_req,
  input  logic                  record_req,
  input  logic                  stop_req,
  input  logic [CHANNELS-1:0]   arm,
  input  logic                  loop_en,
  input  logic [POS_WIDTH-1:0]  loop_start,
  input  logic [POS_WIDTH-1:0]  loop_end,
  input  logic [WORD_WIDTH-1:0] adc_in,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [WORD_WIDTH-1:0] wr_data,
  output logic [CW-1:0]         wr_channel,
  output logic                  rd_req,
  output logic [POS_WIDTH-1:0]  position,
  output logic [1:0]            state_out,
  output logic                  overrun
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PLAY   = 2'd1;
  localparam logic [1:0] ST_RECORD = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CHANNELS-1:0]   pend_q, pend_d;       // armed channels still to be sent this frame
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [CW-1:0]         wr_channel_q, wr_channel_d;
  logic                  rd_req_q, rd_req_d;
  logic [POS_WIDTH-1:0]  pos_q, pos_d;
  logic                  overrun_q, overrun_d;
  logic                  drain_play_q, drain_play_d;
  // Frame that arrived while a beat was stalled; starts once that beat is accepted.
  logic                  nxt_vld_q, nxt_vld_d;
  logic [WORD_WIDTH-1:0] nxt_data_q, nxt_data_d;
  logic [CHANNELS-1:0]   nxt_arm_q, nxt_arm_d;

  logic                  accept, last_beat, leave;
  logic                  load;
  logic [WORD_WIDTH-1:0] ld_data;
  logic [CHANNELS-1:0]   ld_arm;
  logic [1:0]            adv;
  logic [POS_WIDTH-1:0]  pos_p1, pos_p2;

  function automatic logic [CW-1:0] lowest(input logic [CHANNELS-1:0] m);
    lowest = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (m[i]) lowest = i[CW-1:0];
  endfunction

  function automatic logic [POS_WIDTH-1:0] next_pos(input logic [POS_WIDTH-1:0] p);
    if (loop_en && (loop_start <= loop_end) && (p == loop_end)) next_pos = loop_start;
    else next_pos = p + POS_WIDTH'(1);
  endfunction

  assign accept    = wr_valid_q & wr_ready;
  assign last_beat = accept & (pend_q == '0);
  // In RECORD a simultaneous record_req outranks play_req, which makes it a no-op.
  assign leave     = stop_req | (play_req & ~record_req);
  assign pos_p1    = next_pos(pos_q);
  assign pos_p2    = next_pos(pos_p1);

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    data_d       = data_q;
    wr_valid_d   = wr_valid_q;
    wr_channel_d = wr_channel_q;
    rd_req_d     = 1'b0;
    overrun_d    = overrun_q;
    drain_play_d = drain_play_q;
    nxt_vld_d    = nxt_vld_q;
    nxt_data_d   = nxt_data_q;
    nxt_arm_d    = nxt_arm_q;
    adv          = 2'd0;
    load         = 1'b0;
    ld_data      = adc_in;
    ld_arm       = arm;

    case (state_q)
      ST_IDLE: begin
        if (!stop_req) begin
          if (record_req && (arm != '0)) state_d = ST_RECORD;
          else if (play_req) state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (stop_req) state_d = ST_IDLE;
        else if (record_req && (arm != '0)) state_d = ST_RECORD;
        else if (sample_strobe) begin
          rd_req_d = 1'b1;
          adv      = 2'd1;
        end
      end
      ST_RECORD: begin
        if (leave) begin
          pend_d       = '0;
          nxt_vld_d    = 1'b0;
          drain_play_d = ~stop_req;
          if (wr_valid_q && !wr_ready) state_d = ST_DRAIN;
          else begin
            wr_valid_d = 1'b0;
            state_d    = stop_req ? ST_IDLE : ST_PLAY;
          end
        end else begin
          if (accept) begin
            if (pend_q != '0) begin
              wr_channel_d = lowest(pend_q);
              pend_d       = pend_q & (pend_q - CHANNELS'(1));
            end else begin
              wr_valid_d = 1'b0;
              adv        = adv + 2'd1;
            end
          end
          if (sample_strobe) begin
            if (wr_valid_q && !last_beat) overrun_d = 1'b1;
            if (nxt_vld_q) adv = adv + 2'd1;  // a queued frame is superseded unsent
            if (wr_valid_q && !accept) begin
              nxt_vld_d  = 1'b1;
              nxt_data_d = adc_in;
              nxt_arm_d  = arm;
              pend_d     = '0;
            end else begin
              if (accept && (pend_q != '0)) adv = adv + 2'd1;  // rest of old frame dropped
              load      = 1'b1;
              nxt_vld_d = 1'b0;
            end
          end else if (nxt_vld_q && accept) begin
            load      = 1'b1;
            ld_data   = nxt_data_q;
            ld_arm    = nxt_arm_q;
            nxt_vld_d = 1'b0;
          end
        end
      end
      default: begin  // ST_DRAIN
        if (stop_req) drain_play_d = 1'b0;
        if (accept) begin
          wr_valid_d   = 1'b0;
          state_d      = (drain_play_q && !stop_req) ? ST_PLAY : ST_IDLE;
          drain_play_d = 1'b0;
        end
      end
    endcase

    // An empty arm mask yields a frame with no beats and no position step.
    if (load) begin
      data_d       = ld_data;
      wr_valid_d   = (ld_arm != '0);
      wr_channel_d = lowest(ld_arm);
      pend_d       = ld_arm & (ld_arm - CHANNELS'(1));
    end

    case (adv)
      2'd1:    pos_d = pos_p1;
      2'd2:    pos_d = pos_p2;
      default: pos_d = pos_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      pend_q       <= '0;
      data_q       <= '0;
      wr_valid_q   <= 1'b0;
      wr_channel_q <= '0;
      rd_req_q     <= 1'b0;
      pos_q        <= '0;
      overrun_q    <= 1'b0;
      drain_play_q <= 1'b0;
      nxt_vld_q    <= 1'b0;
      nxt_data_q   <= '0;
      nxt_arm_q    <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      data_q       <= data_d;
      wr_valid_q   <= wr_valid_d;
      wr_channel_q <= wr_channel_d;
      rd_req_q     <= rd_req_d;
      pos_q        <= pos_d;
      overrun_q    <= overrun_d;
      drain_play_q <= drain_play_d;
      nxt_vld_q    <= nxt_vld_d;
      nxt_data_q   <= nxt_data_d;
      nxt_arm_q    <= nxt_arm_d;
    end
  end

  assign wr_valid   = wr_valid_q;
  assign wr_data    = data_q;
  assign wr_channel = wr_channel_q;
  assign rd_req     = rd_req_q;
  assign position   = pos_q;
  assign state_out  = state_q;
  assign overrun    = overrun_q;

endmodule
